// File: rtl/five_switch_toggle_light.sv
// Five-way staircase lamp: synchronises and debounces five slide switches and
// flips the lamp on every accepted change. Define FIVE_SWITCH_AUTO_OFF_EN for a lamp-on timeout.
module five_switch_toggle_light #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int DB_CNT_W        = 17,
  parameter int AUTO_OFF_CYCLES = 500000000,
  parameter int AO_CNT_W        = 29
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sw,
  output logic       led,
  output logic [4:0] sw_stable,
  output logic       toggle_pulse
);

  if (DEBOUNCE_CYCLES < 2 ||
      (64'd1 << DB_CNT_W) < 64'(DEBOUNCE_CYCLES) ||
      (64'd1 << AO_CNT_W) < 64'(AUTO_OFF_CYCLES)) begin : g_bad_params
    $error("five_switch_toggle_light: counter widths too small for configured cycle counts");
  end

  localparam logic [DB_CNT_W-1:0] DB_LAST = DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [4:0]          sync1;
  logic [4:0]          sync2;
  logic [DB_CNT_W-1:0] cnt      [5];
  logic [DB_CNT_W-1:0] cnt_next [5];
  logic [4:0]          stable_next;
  logic [4:0]          chg;

  // A counter only runs while the synchronised level disagrees with the
  // accepted level, so it can never pass DB_LAST.
  always_comb begin
    stable_next = sw_stable;
    for (int i = 0; i < 5; i++) begin
      cnt_next[i] = '0;
      if (sync2[i] != sw_stable[i]) begin
        if (cnt[i] == DB_LAST) begin
          stable_next[i] = sync2[i];
        end else begin
          cnt_next[i] = cnt[i] + 1'b1;
        end
      end
    end
    chg = stable_next ^ sw_stable;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1        <= '0;
      sync2        <= '0;
      sw_stable    <= '0;
      toggle_pulse <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1        <= sw;
      sync2        <= sync1;
      sw_stable    <= stable_next;
      toggle_pulse <= |chg;
      for (int i = 0; i < 5; i++) begin
        cnt[i] <= cnt_next[i];
      end
    end
  end

`ifdef FIVE_SWITCH_AUTO_OFF_EN
  localparam logic [AO_CNT_W-1:0] AO_LAST = AO_CNT_W'(AUTO_OFF_CYCLES - 1);

  logic [AO_CNT_W-1:0] ao_cnt;

  // A switch change outranks the timeout and restarts the lamp-on interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      led    <= 1'b0;
      ao_cnt <= '0;
    end else if (|chg) begin
      led    <= led ^ (^chg);
      ao_cnt <= '0;
    end else if (led && ao_cnt == AO_LAST) begin
      led    <= 1'b0;
      ao_cnt <= '0;
    end else if (led) begin
      ao_cnt <= ao_cnt + 1'b1;
    end else begin
      ao_cnt <= '0;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      led <= 1'b0;
    end else begin
      led <= led ^ (^chg);
    end
  end
`endif

endmodule

// File: tb/tb_five_switch_toggle_light.sv
// Bench for five_switch_toggle_light: directed vectors and sequences plus random
// switch activity checked against a sample-window reference model.
module tb_five_switch_toggle_light;
  localparam int DC = 4;
  localparam int AO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] sw  = '0;
  logic       led;
  logic [4:0] sw_stable;
  logic       toggle_pulse;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  five_switch_toggle_light #(
    .DEBOUNCE_CYCLES(DC),
    .DB_CNT_W(3),
    .AUTO_OFF_CYCLES(AO),
    .AO_CNT_W(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sw(sw),
    .led(led),
    .sw_stable(sw_stable),
    .toggle_pulse(toggle_pulse)
  );

  // Reference: a switch level is accepted once the last DC samples seen by the
  // debouncer (raw samples delayed two edges) all disagree with the accepted level.
  logic [4:0] hist [DC+2];
  logic [4:0] m_stable;
  logic       m_led;
  logic       m_pulse;
  int         edge_n   = 0;
  int         last_evt = 0;

  task automatic model_edge();
    logic [4:0] nxt;
    logic [4:0] c;
    bit         held;
    if (rst) begin
      for (int i = 0; i < DC + 2; i++) hist[i] = '0;
      m_stable = '0;
      m_led    = 1'b0;
      m_pulse  = 1'b0;
      last_evt = edge_n;
    end else begin
      for (int i = DC + 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = sw;
      nxt = m_stable;
      for (int b = 0; b < 5; b++) begin
        held = 1'b1;
        for (int k = 2; k <= DC + 1; k++) begin
          if (hist[k][b] == m_stable[b]) held = 1'b0;
        end
        if (held) nxt[b] = ~m_stable[b];
      end
      c = nxt ^ m_stable;
      m_pulse = |c;
      if (|c) begin
        m_led    = m_led ^ (^c);
        last_evt = edge_n;
      end
`ifdef FIVE_SWITCH_AUTO_OFF_EN
      else if (m_led && (edge_n - last_evt) == AO) begin
        m_led    = 1'b0;
        last_evt = edge_n;
      end
`endif
      m_stable = nxt;
    end
  endtask

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s @edge %0d: got sw_stable/led/pulse=%b expected %b", name, edge_n, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_edge();
    #1;
    check("model", {sw_stable, led, toggle_pulse}, {m_stable, m_led, m_pulse});
  endtask

  task automatic expect_out(input string name, input logic [4:0] st, input logic l, input logic p);
    check(name, {sw_stable, led, toggle_pulse}, {st, l, p});
  endtask

  typedef struct {
    logic [4:0] sw;
    logic [4:0] exp_stable;
    logic       exp_led;
    logic       exp_pulse;
  } vec_t;

  vec_t vecs [7];

  initial begin
    logic [4:0] prev_st;
    logic       prev_led;

    vecs[0] = '{5'b00000, 5'b00000, 1'b0, 1'b1};
    vecs[1] = '{5'b00101, 5'b00101, 1'b0, 1'b1};
    vecs[2] = '{5'b00111, 5'b00111, 1'b1, 1'b1};
    vecs[3] = '{5'b10111, 5'b10111, 1'b0, 1'b1};
    vecs[4] = '{5'b11111, 5'b11111, 1'b1, 1'b1};
    vecs[5] = '{5'b01010, 5'b01010, 1'b0, 1'b1};
    vecs[6] = '{5'b00000, 5'b00000, 1'b0, 1'b1};

    // reset, then idle
    rst = 1'b1; sw = '0;
    repeat (3) tick();
    expect_out("reset", 5'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (10) begin tick(); expect_out("idle", 5'b0, 1'b0, 1'b0); end

    // single change: accepted exactly DC+2 edges after first sample
    sw = 5'b00001;
    repeat (5) tick();
    expect_out("single_pre", 5'b00000, 1'b0, 1'b0);
    tick();
    expect_out("single_accept", 5'b00001, 1'b1, 1'b1);
    tick();
    expect_out("single_pulse_end", 5'b00001, 1'b1, 1'b0);
    sw = 5'b00011;
    repeat (5) tick();
    expect_out("second_pre", 5'b00001, 1'b1, 1'b0);
    tick();
    expect_out("second_accept", 5'b00011, 1'b0, 1'b1);
    repeat (2) tick();

    // glitch shorter than the debounce window
    sw = 5'b00111;
    repeat (3) tick();
    sw = 5'b00011;
    repeat (10) begin tick(); expect_out("glitch", 5'b00011, 1'b0, 1'b0); end

    // table vectors, including simultaneous multi-switch changes
    prev_st = 5'b00011; prev_led = 1'b0;
    for (int v = 0; v < 7; v++) begin
      sw = vecs[v].sw;
      repeat (5) tick();
      expect_out("vec_pre", prev_st, prev_led, 1'b0);
      tick();
      expect_out("vec_accept", vecs[v].exp_stable, vecs[v].exp_led, vecs[v].exp_pulse);
      repeat (2) tick();
      prev_st = vecs[v].exp_stable; prev_led = vecs[v].exp_led;
    end

    // reset in the middle of a debounce
    sw = 5'b10000;
    repeat (2) tick();
    rst = 1'b1;
    tick();
    expect_out("mid_reset", 5'b0, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (5) tick();
    expect_out("mid_pre", 5'b0, 1'b0, 1'b0);
    tick();
    expect_out("mid_accept", 5'b10000, 1'b1, 1'b1);
    sw = 5'b00000;
    repeat (8) tick();
    expect_out("mid_back", 5'b0, 1'b0, 1'b0);

`ifdef FIVE_SWITCH_AUTO_OFF_EN
    sw = 5'b00001;
    repeat (6) tick();
    expect_out("ao_on", 5'b00001, 1'b1, 1'b1);
    repeat (19) begin tick(); expect_out("ao_hold", 5'b00001, 1'b1, 1'b0); end
    tick();
    expect_out("ao_timeout", 5'b00001, 1'b0, 1'b0);
    sw = 5'b00011;
    repeat (6) tick();
    expect_out("ao_on2", 5'b00011, 1'b1, 1'b1);
    repeat (14) tick();
    sw = 5'b01111;
    repeat (5) tick();
    expect_out("ao_pre_collide", 5'b00011, 1'b1, 1'b0);
    tick();
    expect_out("ao_collide", 5'b01111, 1'b1, 1'b1);
    repeat (19) tick();
    expect_out("ao_restart_hold", 5'b01111, 1'b1, 1'b0);
    tick();
    expect_out("ao_restart_off", 5'b01111, 1'b0, 1'b0);
`endif

    // random activity: mix of glitches, accepted changes, long holds and resets
    for (int s = 0; s < 200; s++) begin
      if ($urandom_range(0, 3) == 0) sw = 5'($urandom);
      else sw = sw ^ 5'(1 << $urandom_range(0, 4));
      rst = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 9) == 0) repeat (25) tick();
      else repeat ($urandom_range(1, 8)) tick();
      rst = 1'b0;
    end
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
